// File: rtl/k12a_operand_capture.sv
// k12a_operand_capture: A/B operand registers on the shared 8-bit data bus, plus the conditional-skip FSM.
// Latency: loads are visible on a/b one cycle after the edge. Stores drive data_bus combinationally. skip is registered.
// Backpressure: none. skip stays high until SKIP_WORDS skip_ack pulses have been consumed.
//
// Ports: clock/reset (synchronous, active-high); data_bus (inout, tri-state);
//        a_load/b_load capture the bus; a_store/b_store drive A/B onto the bus;
//        a/b feed the ALU; alu_condition/cond_sample/skip_ack drive the skip FSM;
//        skip is registered; bus_conflict is a sticky flag for simultaneous stores.
// Optional macro K12A_COND_INVERT_EN adds the cond_invert input (skip-if-false variants).
module k12a_operand_capture #(
    parameter logic [7:0]  RESET_VALUE = 8'h00,
    parameter int unsigned SKIP_WORDS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire  [7:0] data_bus,
    input  logic       a_load,
    input  logic       b_load,
    input  logic       a_store,
    input  logic       b_store,
    output logic [7:0] a,
    output logic [7:0] b,
    input  logic       alu_condition,
`ifdef K12A_COND_INVERT_EN
    input  logic       cond_invert,
`endif
    input  logic       cond_sample,
    input  logic       skip_ack,
    output logic       skip,
    output logic       bus_conflict
);

    typedef enum logic {
        IDLE     = 1'b0,
        SKIPPING = 1'b1
    } state_t;

    localparam logic [3:0] SKIP_INIT = 4'(SKIP_WORDS);

    logic [7:0] a_q;
    logic [7:0] a_d;
    logic [7:0] b_q;
    logic [7:0] b_d;
    logic       conflict_q;
    logic       conflict_d;
    state_t     state_q;
    logic [3:0] cnt_q;
    logic       skip_q;
    logic       cond_taken;
    logic       drive_a;
    logic       drive_b;

    // Exactly one store may own the bus. Simultaneous stores release it.
    assign drive_a  = a_store & ~b_store;
    assign drive_b  = b_store & ~a_store;
    assign data_bus = drive_a ? a_q : (drive_b ? b_q : 8'hzz);

`ifdef K12A_COND_INVERT_EN
    assign cond_taken = alu_condition ^ cond_invert;
`else
    assign cond_taken = alu_condition;
`endif

    // A load takes whatever is on the bus. A store to the same register in the same cycle
    // puts the register's own value on the bus, so the register keeps its value. A store of
    // one register with a load of the other moves the value between them.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        conflict_d = conflict_q | (a_store & b_store);
        if (a_load) begin
            a_d = data_bus;
        end
        if (b_load) begin
            b_d = data_bus;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q        <= RESET_VALUE;
            b_q        <= RESET_VALUE;
            conflict_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            conflict_q <= conflict_d;
        end
    end

    // Skip FSM. cond_sample is only honoured in IDLE, so a skipped conditional never
    // re-arms the skip. That also holds in the cycle of the final skip_ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            skip_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cond_sample && cond_taken) begin
                        state_q <= SKIPPING;
                        cnt_q   <= SKIP_INIT;
                        skip_q  <= 1'b1;
                    end
                end
                SKIPPING: begin
                    if (skip_ack) begin
                        if (cnt_q == 4'd1) begin
                            state_q <= IDLE;
                            cnt_q   <= 4'd0;
                            skip_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                    skip_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a            = a_q;
    assign b            = b_q;
    assign skip         = skip_q;
    assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_k12a_operand_capture.sv
// Testbench for k12a_operand_capture.
// Instance 0 uses the defaults (RESET_VALUE=8'h00, SKIP_WORDS=1).
// Instance 1 uses RESET_VALUE=8'h81 and SKIP_WORDS=2.
module tb_k12a_operand_capture;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Instance 0 stimulus
    logic       reset = 1'b1;
    logic       tb_en = 1'b0;
    logic [7:0] tb_drv = 8'h00;
    wire  [7:0] bus0;
    logic       a_load = 1'b0;
    logic       b_load = 1'b0;
    logic       a_store = 1'b0;
    logic       b_store = 1'b0;
    logic       alu_condition = 1'b0;
    logic       cond_sample = 1'b0;
    logic       skip_ack = 1'b0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       skip0;
    logic       conf0;

    assign bus0 = tb_en ? tb_drv : 8'hzz;

    // Instance 1 stimulus
    wire  [7:0] bus1;
    logic       a_store1 = 1'b0;
    logic       cond1 = 1'b0;
    logic       alu1 = 1'b0;
    logic       ack1 = 1'b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       skip1;
    logic       conf1;

    k12a_operand_capture dut0 (
        .clock         (clock),
        .reset         (reset),
        .data_bus      (bus0),
        .a_load        (a_load),
        .b_load        (b_load),
        .a_store       (a_store),
        .b_store       (b_store),
        .a             (a0),
        .b             (b0),
        .alu_condition (alu_condition),
`ifdef K12A_COND_INVERT_EN
        .cond_invert   (1'b0),
`endif
        .cond_sample   (cond_sample),
        .skip_ack      (skip_ack),
        .skip          (skip0),
        .bus_conflict  (conf0)
    );

    k12a_operand_capture #(.RESET_VALUE(8'h81), .SKIP_WORDS(2)) dut1 (
        .clock         (clock),
        .reset         (reset),
        .data_bus      (bus1),
        .a_load        (1'b0),
        .b_load        (1'b0),
        .a_store       (a_store1),
        .b_store       (1'b0),
        .a             (a1),
        .b             (b1),
        .alu_condition (alu1),
`ifdef K12A_COND_INVERT_EN
        .cond_invert   (1'b0),
`endif
        .cond_sample   (cond1),
        .skip_ack      (ack1),
        .skip          (skip1),
        .bus_conflict  (conf1)
    );

    // Advance one clock and settle 1ns past the edge. Both drive and sample happen there.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        tb_en  = 1'b1;
        tb_drv = 8'hFF;
        a_load = 1'b1;     // reset must win over a concurrent load
        tick();
        tick();
        reset  = 1'b0;
        a_load = 1'b0;
        tb_drv = 8'hA5;    // bus is released, so the bench's value reads back intact
        #1;
        checks++; if (a0 !== 8'h00) begin errors++; $display("FAIL reset_a got=%h exp=%h", a0, 8'h00); end
        checks++; if (b0 !== 8'h00) begin errors++; $display("FAIL reset_b got=%h exp=%h", b0, 8'h00); end
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL reset_skip got=%b exp=0", skip0); end
        checks++; if (conf0 !== 1'b0) begin errors++; $display("FAIL reset_conflict got=%b exp=0", conf0); end
        checks++; if (bus0 !== 8'hA5) begin errors++; $display("FAIL reset_bus_released got=%h exp=%h", bus0, 8'hA5); end
        checks++; if (a1 !== 8'h81) begin errors++; $display("FAIL reset_a_inst1 got=%h exp=%h", a1, 8'h81); end
        checks++; if (b1 !== 8'h81) begin errors++; $display("FAIL reset_b_inst1 got=%h exp=%h", b1, 8'h81); end
        checks++; if (skip1 !== 1'b0 || conf1 !== 1'b0) begin errors++; $display("FAIL reset_flags_inst1 got=%b%b exp=00", skip1, conf1); end
        a_store1 = 1'b1;
        #1;
        checks++; if (bus1 !== 8'h81) begin errors++; $display("FAIL store_inst1 got=%h exp=%h", bus1, 8'h81); end
        a_store1 = 1'b0;
        tb_en = 1'b0;
    endtask

    task automatic test_load_store();
        tb_en  = 1'b1;
        tb_drv = 8'h5A;
        a_load = 1'b1;
        #1;
        checks++; if (a0 !== 8'h00) begin errors++; $display("FAIL load_no_comb_path got=%h exp=%h", a0, 8'h00); end
        tick();
        a_load = 1'b0;
        tb_en  = 1'b0;
        checks++; if (a0 !== 8'h5A) begin errors++; $display("FAIL load_a got=%h exp=%h", a0, 8'h5A); end
        checks++; if (b0 !== 8'h00) begin errors++; $display("FAIL load_a_b_untouched got=%h exp=%h", b0, 8'h00); end
        a_store = 1'b1;
        #1;
        checks++; if (bus0 !== 8'h5A) begin errors++; $display("FAIL store_a_bus got=%h exp=%h", bus0, 8'h5A); end
        tick();
        a_store = 1'b0;
        // load B with a distinct value and read it back through the bus
        tb_en  = 1'b1;
        tb_drv = 8'h77;
        b_load = 1'b1;
        tick();
        b_load = 1'b0;
        tb_en  = 1'b0;
        checks++; if (b0 !== 8'h77) begin errors++; $display("FAIL load_b got=%h exp=%h", b0, 8'h77); end
        checks++; if (a0 !== 8'h5A) begin errors++; $display("FAIL load_b_a_untouched got=%h exp=%h", a0, 8'h5A); end
        b_store = 1'b1;
        #1;
        checks++; if (bus0 !== 8'h77) begin errors++; $display("FAIL store_b_bus got=%h exp=%h", bus0, 8'h77); end
        // store and load of the same register leaves it unchanged
        b_load = 1'b1;
        tick();
        b_store = 1'b0;
        b_load  = 1'b0;
        checks++; if (b0 !== 8'h77) begin errors++; $display("FAIL store_load_same got=%h exp=%h", b0, 8'h77); end
        // both loads together take the same bus value
        tb_en  = 1'b1;
        tb_drv = 8'hE1;
        a_load = 1'b1;
        b_load = 1'b1;
        tick();
        a_load = 1'b0;
        b_load = 1'b0;
        tb_en  = 1'b0;
        checks++; if (a0 !== 8'hE1 || b0 !== 8'hE1) begin errors++; $display("FAIL dual_load got=%h/%h exp=e1/e1", a0, b0); end
    endtask

    task automatic test_move_conflict();
        tb_en  = 1'b1;
        tb_drv = 8'h3C;
        a_load = 1'b1;
        tick();
        a_load = 1'b0;
        tb_en  = 1'b0;
        a_store = 1'b1;
        b_load  = 1'b1;
        tick();
        a_store = 1'b0;
        b_load  = 1'b0;
        checks++; if (b0 !== 8'h3C) begin errors++; $display("FAIL move_a_to_b got=%h exp=%h", b0, 8'h3C); end
        checks++; if (conf0 !== 1'b0) begin errors++; $display("FAIL move_no_conflict got=%b exp=0", conf0); end
        a_store = 1'b1;
        b_store = 1'b1;
        tb_en   = 1'b1;
        tb_drv  = 8'h96;   // with the DUT released this reads back unchanged
        #1;
        checks++; if (bus0 !== 8'h96) begin errors++; $display("FAIL conflict_bus_released got=%h exp=%h", bus0, 8'h96); end
        checks++; if (conf0 !== 1'b0) begin errors++; $display("FAIL conflict_not_early got=%b exp=0", conf0); end
        tick();
        tb_en   = 1'b0;
        a_store = 1'b0;
        b_store = 1'b0;
        checks++; if (conf0 !== 1'b1) begin errors++; $display("FAIL conflict_set got=%b exp=1", conf0); end
        tick();
        tick();
        checks++; if (conf0 !== 1'b1) begin errors++; $display("FAIL conflict_sticky got=%b exp=1", conf0); end
        checks++; if (a0 !== 8'h3C || b0 !== 8'h3C) begin errors++; $display("FAIL conflict_regs got=%h/%h exp=3c/3c", a0, b0); end
    endtask

    task automatic test_skip();
        // not taken
        cond_sample   = 1'b1;
        alu_condition = 1'b0;
        tick();
        cond_sample = 1'b0;
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL not_taken got=%b exp=0", skip0); end
        // skip_ack in IDLE is ignored
        skip_ack = 1'b1;
        tick();
        skip_ack = 1'b0;
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL ack_in_idle got=%b exp=0", skip0); end
        // taken
        cond_sample   = 1'b1;
        alu_condition = 1'b1;
        #1;
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL skip_not_comb got=%b exp=0", skip0); end
        tick();
        cond_sample   = 1'b0;
        alu_condition = 1'b0;
        checks++; if (skip0 !== 1'b1) begin errors++; $display("FAIL skip_rise got=%b exp=1", skip0); end
        tick();
        checks++; if (skip0 !== 1'b1) begin errors++; $display("FAIL skip_hold got=%b exp=1", skip0); end
        skip_ack = 1'b1;
        tick();
        skip_ack = 1'b0;
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL skip_fall got=%b exp=0", skip0); end
    endtask

    task automatic test_skip_words2();
        cond1 = 1'b1;
        alu1  = 1'b1;
        tick();
        cond1 = 1'b0;
        alu1  = 1'b0;
        checks++; if (skip1 !== 1'b1) begin errors++; $display("FAIL sw2_rise got=%b exp=1", skip1); end
        ack1 = 1'b1;
        tick();
        checks++; if (skip1 !== 1'b1) begin errors++; $display("FAIL sw2_after_ack1 got=%b exp=1", skip1); end
        tick();
        ack1 = 1'b0;
        checks++; if (skip1 !== 1'b0) begin errors++; $display("FAIL sw2_after_ack2 got=%b exp=0", skip1); end
    endtask

    task automatic test_no_chain();
        cond_sample   = 1'b1;
        alu_condition = 1'b1;
        tick();
        checks++; if (skip0 !== 1'b1) begin errors++; $display("FAIL chain_enter got=%b exp=1", skip0); end
        // final ack together with another taken conditional: no chaining
        skip_ack = 1'b1;
        tick();
        skip_ack      = 1'b0;
        cond_sample   = 1'b0;
        alu_condition = 1'b0;
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL chain_final_ack got=%b exp=0", skip0); end
        tick();
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL chain_stays_idle got=%b exp=0", skip0); end
    endtask

    task automatic test_reset_mid();
        tb_en  = 1'b1;
        tb_drv = 8'hFF;
        a_load = 1'b1;
        tick();
        a_load = 1'b0;
        tb_en  = 1'b0;
        cond_sample   = 1'b1;
        alu_condition = 1'b1;
        tick();
        cond_sample   = 1'b0;
        alu_condition = 1'b0;
        checks++; if (a0 !== 8'hFF || skip0 !== 1'b1) begin errors++; $display("FAIL mid_setup got=%h/%b exp=ff/1", a0, skip0); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL mid_reset_skip got=%b exp=0", skip0); end
        checks++; if (a0 !== 8'h00) begin errors++; $display("FAIL mid_reset_a got=%h exp=%h", a0, 8'h00); end
        checks++; if (conf0 !== 1'b0) begin errors++; $display("FAIL mid_reset_conflict got=%b exp=0", conf0); end
        // FSM is in IDLE: an ack must not matter, and a new taken skip works normally
        skip_ack = 1'b1;
        tick();
        skip_ack = 1'b0;
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL mid_idle_ack got=%b exp=0", skip0); end
        cond_sample   = 1'b1;
        alu_condition = 1'b1;
        tick();
        cond_sample   = 1'b0;
        alu_condition = 1'b0;
        skip_ack      = 1'b1;
        tick();
        skip_ack = 1'b0;
        checks++; if (skip0 !== 1'b0) begin errors++; $display("FAIL mid_fresh_skip got=%b exp=0", skip0); end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_move_conflict();
        test_skip();
        test_skip_words2();
        test_no_chain();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/k12a_operand_capture.md
Name: k12a_operand_capture

Overview:
Receive-side counterpart of the ALU on the shared 8-bit data bus.
- Captures bus values into the A and B operand registers, which feed the ALU `a` and `b` inputs.
- Can drive A or B back onto the bus as a store.
- Latches the ALU's `alu_condition` into a registered skip state machine, which the control unit uses to suppress the next SKIP_WORDS instruction words.
- Sits between the data bus, the ALU and the control unit.

Parameters:
- RESET_VALUE, 8'h00, value loaded into A and B on reset.
- SKIP_WORDS, 1, number of `skip_ack` pulses consumed per taken skip. Legal range 1..15.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_bus  inout  8  shared tri-state data bus.
- a_load  input  1  capture `data_bus` into A at the clock edge.
- b_load  input  1  capture `data_bus` into B at the clock edge.
- a_store  input  1  drive A onto `data_bus` (combinational).
- b_store  input  1  drive B onto `data_bus` (combinational).
- a  output  8  A register contents, to the ALU.
- b  output  8  B register contents, to the ALU.
- alu_condition  input  1  condition result from the ALU.
- cond_sample  input  1  strobe: a conditional-skip instruction is executing this cycle.
- skip_ack  input  1  control unit has suppressed one instruction word.
- skip  output  1  registered: the next instruction word(s) must be suppressed.
- bus_conflict  output  1  sticky error: `a_store` and `b_store` were asserted together.

Behaviour:
Reset
- While `reset` is high at a clock edge: `a` = `b` = RESET_VALUE, `skip` = 0, `bus_conflict` = 0, FSM = IDLE, skip counter = 0.
- `data_bus` is released (8'hzz) whenever no store is active, including during reset.
- `reset` takes priority over every other input in the same cycle.

Loads
- `a_load` at an edge: A <= `data_bus`. `b_load` at an edge: B <= `data_bus`.
- Both loads in the same cycle are legal; both registers take the same bus value.
- `a`, `b` update one cycle after the load edge; zero combinational path from `data_bus` to `a`/`b`.
- Load while nothing drives the bus: the result is undefined; the bench must not do this.

Stores
- `data_bus` = A if `a_store` & ~`b_store`; B if `b_store` & ~`a_store`; otherwise 8'hzz.
- `a_store` & `b_store` together: bus released; `bus_conflict` is set at the next edge and stays set until reset.
- Store and load of the same register in one cycle: the register reloads its own value, so it is unchanged.
- Store of A with load of B in one cycle is a legal register-to-register move: B <= A.

Skip FSM (states IDLE, SKIPPING)
- IDLE:
  - `cond_sample` & `alu_condition` -> SKIPPING, counter <= SKIP_WORDS, `skip` <= 1.
  - `cond_sample` & ~`alu_condition` -> stay in IDLE.
  - `skip_ack` is ignored.
- SKIPPING:
  - `skip` = 1.
  - Each `skip_ack` decrements the counter.
  - `skip_ack` when counter == 1 -> IDLE, `skip` <= 0.
- Latency: `skip` rises exactly one cycle after the sampling edge and falls one cycle after the final `skip_ack` edge.
- `cond_sample` in SKIPPING is ignored, including in the same cycle as the final `skip_ack`; a skipped conditional instruction never chains.
- Counter is 4 bits wide and never wraps; `skip_ack` with counter == 0 cannot occur outside IDLE.

Optional Feature:
K12A_COND_INVERT_EN
- Defined: adds input port `cond_invert` (1 bit). The sampled condition is `alu_condition` ^ `cond_invert`, giving skip-if-false variants.
- Undefined: the port is absent and `alu_condition` is used directly.

Test Plan:
- Reset check: assert `reset` with RESET_VALUE=8'h00 -> `a`=`b`=8'h00, `skip`=0, `bus_conflict`=0, `data_bus`=8'hzz.
- Load and store: bench drives 8'h5A with `a_load`, then releases the bus and asserts `a_store` -> `a`=8'h5A next cycle; `data_bus`=8'h5A while `a_store` is high.
- Register move and conflict:
  - With A=8'h3C, assert `a_store` + `b_load` -> B=8'h3C.
  - Then assert `a_store` + `b_store` -> `data_bus`=8'hzz and `bus_conflict`=1 until reset.
- Taken skip: `cond_sample`=1, `alu_condition`=1 -> `skip`=1 next cycle. Then `skip_ack` -> `skip`=0 next cycle. With SKIP_WORDS=2, two acks are needed.
- Not-taken and ignored strobes:
  - `cond_sample` with `alu_condition`=0 -> `skip` stays 0.
  - In SKIPPING, `cond_sample`=1 in the same cycle as the final `skip_ack` -> returns to IDLE, `skip`=0.
- Reset mid-operation: `reset` asserted while SKIPPING with A=8'hFF -> `skip`=0, A=RESET_VALUE, FSM=IDLE.
